// File: rtl/feature_loader_ctrl.sv
// feature_loader_ctrl: fills the feature loader staging register from activation
// memory, one memory word per beat, then holds features_valid_o until consumed.
module feature_loader_ctrl #(
  parameter int unsigned inputWidth   = 256,
  parameter int unsigned addrWidth    = 8,
  parameter int unsigned elementWidth = 8,
  parameter int unsigned numElements  = 128,
  parameter int unsigned memAddrWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [memAddrWidth-1:0] base_addr_i,
  input  logic [addrWidth-1:0]    num_elements_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic                    mem_req_o,
  output logic [memAddrWidth-1:0] mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [inputWidth-1:0]   mem_rdata_i,
  output logic                    fl_wr_en_o,
  output logic [addrWidth-1:0]    fl_addr_o,
  output logic [inputWidth-1:0]   fl_data_o,
  output logic                    features_valid_o,
  input  logic                    consume_i
);

  localparam int unsigned EPW = inputWidth / elementWidth;
  // One extra bit so element counts and offsets never overflow in intermediate math.
  localparam int unsigned CW  = addrWidth + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t                  state_q, state_d;
  logic [memAddrWidth-1:0] base_q;
  logic [CW-1:0]           n_q, beats_q, issued_q, returned_q;
  logic                    err_q, wr_en_q;
  logic [addrWidth-1:0]    fl_addr_q;
  logic [inputWidth-1:0]   fl_data_q;

  logic [CW-1:0]           n_ext, cmd_beats, ret_base, lanes_left;
  logic                    cmd_ok, accept, reject;
  logic                    grant, last_grant, take_ret, last_ret;
  logic [inputWidth-1:0]   masked_data;

  // Command decode, request/return bookkeeping and final-beat lane masking.
  always_comb begin
    n_ext      = CW'(num_elements_i);
    cmd_ok     = (n_ext != '0) && (n_ext <= CW'(numElements));
    cmd_beats  = (n_ext + CW'(EPW - 1)) / CW'(EPW);
    accept     = (state_q == IDLE) && start_i && cmd_ok;
    reject     = (state_q == IDLE) && start_i && !cmd_ok;
    grant      = (state_q == FETCH) && mem_gnt_i;
    last_grant = grant && ((issued_q + CW'(1)) == beats_q);
    take_ret   = mem_rvalid_i && ((state_q == FETCH) || (state_q == DRAIN));
    last_ret   = (returned_q + CW'(1)) == beats_q;
    ret_base   = returned_q * CW'(EPW);
    lanes_left = n_q - ret_base;
    masked_data = mem_rdata_i;
    for (int unsigned i = 0; i < EPW; i++) begin
      if (last_ret && (CW'(i) >= lanes_left)) begin
        masked_data[i*elementWidth +: elementWidth] = '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)                 state_d = FETCH;
      FETCH: if (last_grant)             state_d = DRAIN;
      DRAIN: if (returned_q == beats_q)  state_d = READY;
      READY: if (consume_i)              state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // State, counters and registered feature-loader write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      n_q        <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      fl_addr_q  <= '0;
      fl_data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        base_q     <= base_addr_i;
        n_q        <= n_ext;
        beats_q    <= cmd_beats;
        issued_q   <= '0;
        returned_q <= '0;
      end else begin
        if (grant)    issued_q   <= issued_q + CW'(1);
        if (take_ret) returned_q <= returned_q + CW'(1);
      end
      wr_en_q <= take_ret;
      if (take_ret) begin
        fl_addr_q <= addrWidth'(ret_base);
        fl_data_q <= masked_data;
      end
    end
  end

  assign busy_o           = (state_q == FETCH) || (state_q == DRAIN);
  assign mem_req_o        = (state_q == FETCH);
  assign mem_addr_o       = (state_q == FETCH) ? (base_q + memAddrWidth'(issued_q)) : '0;
  assign features_valid_o = (state_q == READY);
  assign err_o            = err_q;
  assign fl_wr_en_o       = wr_en_q;
  assign fl_addr_o        = fl_addr_q;
  assign fl_data_o        = fl_data_q;

endmodule
